// File: rtl/multiplier_pkg.sv
// Shared constants and types for the tiled sequential multiplier.
// The tile width, FSM state encoding and index width helper live here.
package multiplier_pkg;

  localparam int TILE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Keep at least one bit so a single-slice counter still has a net.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multiplier_4x4.sv
// 4x4 unsigned multiplier tile.
// It is reused every cycle by the sequential tiled multiplier.
module multiplier_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'b0, a} * {4'b0, b};

endmodule

// File: rtl/tiled_multiplier_seq.sv
// Sequential WIDTHxWIDTH unsigned multiplier using one shared 4x4 tile.
// One tile per cycle, with optional dropping of low-significance tiles.
module tiled_multiplier_seq
  import multiplier_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SKIP_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out
);

  localparam int N  = WIDTH / TILE_W;
  localparam int IW = idx_w(N);
  localparam int PW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  if ((WIDTH % TILE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("tiled_multiplier_seq: WIDTH must be a multiple of 4 and >= 8");
  end
  if (SKIP_LOW < 0 || SKIP_LOW > 2 * N - 1) begin : g_bad_skip
    $error("tiled_multiplier_seq: SKIP_LOW out of range");
  end

  state_t          state;
  state_t          state_nx;
  logic [IW-1:0]   i;
  logic [IW-1:0]   j;
  logic [IW:0]     ij;
  logic [WIDTH-1:0] aq;
  logic [WIDTH-1:0] bq;
  logic [3:0]      sa;
  logic [3:0]      sb;
  logic [7:0]      tile_p;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   acc_sum;
  logic [PW-1:0]   out_q;
  logic            last;

  assign sa = aq[{i, 2'b00} +: TILE_W];
  assign sb = bq[{j, 2'b00} +: TILE_W];

  multiplier_4x4 u_tile (
    .a (sa),
    .b (sb),
    .p (tile_p)
  );

  assign ij   = {1'b0, i} + {1'b0, j};
  assign last = (i == LAST_IDX) && (j == LAST_IDX);

  // Skipped tiles still consume their cycle so latency stays fixed.
  always_comb begin
    addend = '0;
    if (int'(ij) >= SKIP_LOW)
      addend = {{(PW-8){1'b0}}, tile_p} << {ij, 2'b00};
  end

  assign acc_sum = acc + addend;
  assign out     = out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aq    <= '0;
      bq    <= '0;
      acc   <= '0;
      out_q <= '0;
      i     <= '0;
      j     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            aq    <= a;
            bq    <= b;
            acc   <= '0;
            out_q <= '0;
            i     <= '0;
            j     <= '0;
          end
        end
        RUN: begin
          acc <= acc_sum;
          if (last) out_q <= acc_sum;
          // i sweeps fastest; j advances when i wraps.
          if (i == LAST_IDX) begin
            i <= '0;
            j <= (j == LAST_IDX) ? '0 : j + 1'b1;
          end else begin
            i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tiled_multiplier_seq.sv
// Randomised self-checking bench for tiled_multiplier_seq.
// Covers exact 16-bit, approximate/exact 8-bit, backpressure, reset, streaming.
module tb_tiled_multiplier_seq;

  logic        clk;
  logic        rst;

  logic        in_valid16;
  logic        in_ready16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        out_valid16;
  logic        out_ready16;
  logic [31:0] out16;

  logic        iv8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        out_ready8;
  logic        in_ready8a;
  logic        in_ready8e;
  logic        out_valid8a;
  logic        out_valid8e;
  logic [15:0] out8a;
  logic [15:0] out8e;

  int checks = 0;
  int errors = 0;

  tiled_multiplier_seq #(.WIDTH(16), .SKIP_LOW(0)) u16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out       (out16)
  );

  tiled_multiplier_seq #(.WIDTH(8), .SKIP_LOW(2)) u8a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (in_ready8a),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8a),
    .out_ready (out_ready8),
    .out       (out8a)
  );

  tiled_multiplier_seq #(.WIDTH(8), .SKIP_LOW(0)) u8e (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (in_ready8e),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8e),
    .out_ready (out_ready8),
    .out       (out8e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: sum of surviving 4-bit digit products at their weights.
  function automatic logic [63:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input int w, input int skip);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int ii = 0; ii < w / 4; ii++) begin
      for (int jj = 0; jj < w / 4; jj++) begin
        if (ii + jj >= skip) begin
          t = 64'((x >> (4 * ii)) & 32'hF);
          t = t * 64'((y >> (4 * jj)) & 32'hF);
          r = r + (t << (4 * (ii + jj)));
        end
      end
    end
    return r;
  endfunction

  task automatic run16(input logic [15:0] x, input logic [15:0] y);
    int n;
    @(negedge clk);
    chk("ready16", 64'(in_ready16), 64'd1);
    a16 = x;
    b16 = y;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat16", 64'(n), 64'd16);
    chk("prod16", 64'(out16), ref_mul(32'(x), 32'(y), 16, 0));
    @(posedge clk); #1;
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y);
    int n;
    @(negedge clk);
    a8  = x;
    b8  = y;
    iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 0;
    while (!out_valid8a && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("lat8", 64'(n), 64'd4);
    chk("prod8_skip2", 64'(out8a), ref_mul(32'(x), 32'(y), 8, 2));
    chk("valid8_exact", 64'(out_valid8e), 64'd1);
    chk("prod8_exact", 64'(out8e), ref_mul(32'(x), 32'(y), 8, 0));
    @(posedge clk); #1;
  endtask

  task automatic no_result(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_valid16) seen++;
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  task automatic backpressure();
    int n;
    logic [31:0] hold;
    out_ready16 = 1'b0;
    @(negedge clk);
    a16 = 16'hA5C3;
    b16 = 16'h3C5A;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_lat", 64'(n), 64'd16);
    hold = out16;
    chk("bp_prod", 64'(hold), ref_mul(32'hA5C3, 32'h3C5A, 16, 0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      in_valid16 = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", 64'(out_valid16), 64'd1);
      chk("bp_stable", 64'(out16), 64'(hold));
      chk("bp_inready", 64'(in_ready16), 64'd0);
    end
    @(negedge clk);
    in_valid16  = 1'b0;
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(out_valid16), 64'd0);
    chk("bp_release_ready", 64'(in_ready16), 64'd1);
    no_result("bp_not_accepted", 24);
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    a16 = 16'hFFFF;
    b16 = 16'h1234;
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid16), 64'd0);
    chk("rst_ready", 64'(in_ready16), 64'd1);
    chk("rst_out", 64'(out16), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    no_result("rst_no_stale", 24);
    run16(16'd3, 16'd5);
  endtask

  task automatic back_to_back();
    logic [63:0] q[$];
    logic [15:0] x;
    logic [15:0] y;
    logic        acc_now;
    int cyc;
    int last_acc;
    int sent;
    int got;
    cyc = 0;
    last_acc = -1;
    sent = 0;
    got = 0;
    out_ready16 = 1'b1;
    x = 16'($urandom);
    y = 16'($urandom);
    @(negedge clk);
    a16 = x;
    b16 = y;
    in_valid16 = 1'b1;
    while (got < 4 && cyc < 200) begin
      if (out_valid16) begin
        if (q.size() > 0) chk("b2b_out", 64'(out16), q.pop_front());
        else              chk("b2b_extra", 64'(out_valid16), 64'd0);
        got++;
      end
      acc_now = in_ready16 && in_valid16;
      if (acc_now) begin
        q.push_back(ref_mul(32'(x), 32'(y), 16, 0));
        if (last_acc >= 0) chk("b2b_gap", 64'(cyc - last_acc), 64'd18);
        last_acc = cyc;
        sent++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        if (sent < 4) begin
          x = 16'($urandom);
          y = 16'($urandom);
          a16 = x;
          b16 = y;
        end else begin
          in_valid16 = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid16 = 1'b0;
    chk("b2b_count", 64'(got), 64'd4);
  endtask

  initial begin
    rst = 1'b1;
    in_valid16 = 1'b0;
    a16 = '0;
    b16 = '0;
    out_ready16 = 1'b1;
    iv8 = 1'b0;
    a8 = '0;
    b8 = '0;
    out_ready8 = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", 64'(out_valid16), 64'd0);
    chk("reset_ready", 64'(in_ready16), 64'd1);
    chk("reset_out", 64'(out16), 64'd0);
    rst = 1'b0;

    run16(16'hFFFF, 16'hFFFF);
    chk("ffff_const", 64'(out16), 64'hFFFE0001);
    run16(16'h1234, 16'h5678);
    run16(16'h0000, 16'hBEEF);
    for (int k = 0; k < 6; k++)
      run16(16'($urandom), 16'($urandom));

    backpressure();
    reset_mid_run();

    run8(8'hFF, 8'hFF);
    chk("ff8_skip_const", 64'(out8a), 64'hE100);
    for (int k = 0; k < 4; k++)
      run8(8'($urandom), 8'($urandom));

    back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
